// File: rtl/rx_ethernet_filter.sv
`default_nettype none
// ============================================================================
// Module   : rx_ethernet_filter
// Purpose  : GMII receive MAC front end. Parses preamble/SFD, destination
//            MAC, source MAC and EtherType. Accepts unicast-to-self and,
//            optionally, broadcast frames whose EtherType is in TYPE_LIST.
//            Streams the payload with the 4-byte FCS stripped, and reports
//            per-frame status plus saturating frame/drop counters.
// Optional : RX_FCS_CHECK_EN - when defined, a CRC-32 residue check on
//            dst..FCS produces status 1 on a bad FCS. When undefined, no
//            CRC logic is built and status 1 never occurs.
// Ports    : RX_CLK, rst          - clock, synchronous active-high reset
//            mac_addr             - station address
//            RX_DV, RXD, RX_ER    - GMII receive interface
//            rx_payload*          - payload byte stream (valid, sof)
//            rx_chan, rx_mac_src  - matched TYPE_LIST index, source MAC
//            rx_done, rx_status   - end-of-frame pulse and status code
//            rx_irq               - pulse with rx_done on status 0
//            rx_frame_cnt         - good frame counter (saturating)
//            rx_drop_cnt          - bad frame counter (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module rx_ethernet_filter #(
  parameter int                        OCT          = 8,
  parameter int                        NUM_TYPES    = 2,
  parameter logic [NUM_TYPES*16-1:0]   TYPE_LIST    = {16'h0806, 16'h0800},
  parameter bit                        ACCEPT_BCAST = 1'b1,
  parameter int                        MIN_PAYLOAD  = 46,
  parameter int                        MAX_PAYLOAD  = 1500,
  parameter int                        CNT_W        = 16,
  localparam int                       CHAN_W       = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1
) (
  input  logic              RX_CLK,
  input  logic              rst,
  input  logic [47:0]       mac_addr,
  input  logic              RX_DV,
  input  logic [OCT-1:0]    RXD,
  input  logic              RX_ER,
  output logic [OCT-1:0]    rx_payload,
  output logic              rx_payload_valid,
  output logic              rx_payload_sof,
  output logic [CHAN_W-1:0] rx_chan,
  output logic [47:0]       rx_mac_src,
  output logic              rx_done,
  output logic [1:0]        rx_status,
  output logic              rx_irq,
  output logic [CNT_W-1:0]  rx_frame_cnt,
  output logic [CNT_W-1:0]  rx_drop_cnt
);

  localparam logic [10:0] MIN_P = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_P = 11'(MAX_PAYLOAD);

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_SIZE  = 2'd2;
  localparam logic [1:0] ST_PHY   = 2'd3;
`ifdef RX_FCS_CHECK_EN
  localparam logic [1:0] ST_FCS   = 2'd1;
`endif

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PREAMBLE = 4'd1,
    S_MAC_DST  = 4'd2,
    S_MAC_SRC  = 4'd3,
    S_LEN_TYPE = 4'd4,
    S_PAYLOAD  = 4'd5,
    S_ABORT    = 4'd6,   // stopped with a pending status, waiting for RX_DV low
    S_DONE     = 4'd7,
    S_DISCARD  = 4'd8    // silent drop, waiting for RX_DV low
  } state_t;

  state_t state, state_nx;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic                     dv_prev;
  logic [2:0]               byte_cnt;     // position within header field
  logic                     ucast_ok;     // dst bytes so far equal mac_addr
  logic                     bcast_ok;     // dst bytes so far all 0xFF
  logic [47:0]              src_shadow;
  logic [OCT-1:0]           type_hi;
  logic [CHAN_W-1:0]        chan_shadow;
  logic [3:0][OCT-1:0]      dline;        // [0] newest, [3] oldest
  logic [2:0]               fill;         // bytes held in dline (0..4)
  logic [10:0]              pcnt;         // payload bytes output
  logic                     aborted;
  logic [1:0]               abort_code;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [7:0]               mac_byte;
  logic                     dst_hit;
  logic                     type_hit;
  logic [CHAN_W-1:0]        type_idx;
  logic                     full;
  logic                     fcs_bad;
  logic [1:0]               status_now;

  logic                     shift_en;
  logic                     emit;
  logic                     abort_go;
  logic [1:0]               abort_code_nx;

  // Destination address byte expected at the current position, MSB first.
  always_comb begin
    mac_byte = mac_addr[7:0];
    case (byte_cnt)
      3'd0:    mac_byte = mac_addr[47:40];
      3'd1:    mac_byte = mac_addr[39:32];
      3'd2:    mac_byte = mac_addr[31:24];
      3'd3:    mac_byte = mac_addr[23:16];
      3'd4:    mac_byte = mac_addr[15:8];
      default: mac_byte = mac_addr[7:0];
    endcase
  end

  // The decision is taken on the 6th byte, so it folds in the live byte.
  assign dst_hit = (ucast_ok && (RXD == mac_byte)) ||
                   (ACCEPT_BCAST && bcast_ok && (RXD == 8'hFF));

  // Descending scan so the lowest matching index is the one that sticks.
  always_comb begin
    type_hit = 1'b0;
    type_idx = '0;
    for (int i = NUM_TYPES - 1; i >= 0; i--) begin
      if (TYPE_LIST[16*i +: 16] == {type_hi, RXD}) begin
        type_hit = 1'b1;
        type_idx = CHAN_W'(i);
      end
    end
  end

  assign full = (fill == 3'd4);

  // --------------------------------------------------------------------------
  // Optional FCS check
  // --------------------------------------------------------------------------
`ifdef RX_FCS_CHECK_EN
  logic [31:0] crc;
  logic [31:0] crc_rev;
  logic        crc_init;
  logic        crc_en;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Preset during the preamble so the first dst byte starts from all-ones.
  assign crc_init = (state == S_PREAMBLE);
  assign crc_en   = RX_DV && ((state == S_MAC_DST) || (state == S_MAC_SRC) ||
                              (state == S_LEN_TYPE) || (state == S_PAYLOAD));

  always_ff @(posedge RX_CLK) begin
    if (rst)           crc <= 32'hFFFF_FFFF;
    else if (crc_init) crc <= 32'hFFFF_FFFF;
    else if (crc_en)   crc <= crc32_byte(crc, RXD);
  end

  // The reflected register is bit-reversed relative to the magic residue.
  always_comb begin
    crc_rev = '0;
    for (int i = 0; i < 32; i++) crc_rev[i] = crc[31-i];
  end

  assign fcs_bad = (crc_rev != 32'hC704DD7B);
`else
  assign fcs_bad = 1'b0;
`endif

  // End-of-frame status, highest precedence first. fill < 4 means the frame
  // ended before a full FCS was seen (truncated).
  always_comb begin
    status_now = ST_OK;
    if (aborted)                 status_now = abort_code;
    else if (!full)              status_now = ST_PHY;
    else if (pcnt < MIN_P)       status_now = ST_SIZE;
`ifdef RX_FCS_CHECK_EN
    else if (fcs_bad)            status_now = ST_FCS;
`endif
    else                         status_now = ST_OK;
  end

  // --------------------------------------------------------------------------
  // FSM next state and datapath strobes
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx      = state;
    shift_en      = 1'b0;
    emit          = 1'b0;
    abort_go      = 1'b0;
    abort_code_nx = ST_OK;
    case (state)
      S_IDLE: begin
        if (RX_DV && !dv_prev) state_nx = S_PREAMBLE;
      end
      S_PREAMBLE: begin
        if (!RX_DV)              state_nx = S_IDLE;
        else if (RXD == 8'hD5)   state_nx = S_MAC_DST;
        else if (RXD != 8'h55)   state_nx = S_DISCARD;
      end
      S_MAC_DST: begin
        if (!RX_DV)                 state_nx = S_IDLE;
        else if (RX_ER)             state_nx = S_DISCARD;
        else if (byte_cnt == 3'd5)  state_nx = dst_hit ? S_MAC_SRC : S_DISCARD;
      end
      S_MAC_SRC: begin
        if (!RX_DV)                 state_nx = S_IDLE;
        else if (RX_ER)             state_nx = S_DISCARD;
        else if (byte_cnt == 3'd5)  state_nx = S_LEN_TYPE;
      end
      S_LEN_TYPE: begin
        if (!RX_DV)                 state_nx = S_IDLE;
        else if (RX_ER)             state_nx = S_DISCARD;
        else if (byte_cnt == 3'd1)  state_nx = type_hit ? S_PAYLOAD : S_DISCARD;
      end
      S_PAYLOAD: begin
        if (!RX_DV) begin
          state_nx = S_DONE;
        end else begin
          // The byte due out this cycle still leaves, unless it would be
          // one past the maximum payload length.
          if (full) begin
            if (pcnt == MAX_P) begin
              abort_go      = 1'b1;
              abort_code_nx = ST_SIZE;
              state_nx      = S_ABORT;
            end else begin
              emit = 1'b1;
            end
          end
          // A PHY error outranks a giant.
          if (RX_ER) begin
            abort_go      = 1'b1;
            abort_code_nx = ST_PHY;
            state_nx      = S_ABORT;
          end else begin
            shift_en = 1'b1;
          end
        end
      end
      S_ABORT: begin
        if (!RX_DV) state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      S_DISCARD: begin
        if (!RX_DV) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, datapath and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      state            <= S_IDLE;
      dv_prev          <= 1'b0;
      byte_cnt         <= '0;
      ucast_ok         <= 1'b0;
      bcast_ok         <= 1'b0;
      src_shadow       <= '0;
      type_hi          <= '0;
      chan_shadow      <= '0;
      dline            <= '0;
      fill             <= '0;
      pcnt             <= '0;
      aborted          <= 1'b0;
      abort_code       <= '0;
      rx_payload       <= '0;
      rx_payload_valid <= 1'b0;
      rx_payload_sof   <= 1'b0;
      rx_chan          <= '0;
      rx_mac_src       <= '0;
      rx_done          <= 1'b0;
      rx_status        <= '0;
      rx_irq           <= 1'b0;
      rx_frame_cnt     <= '0;
      rx_drop_cnt      <= '0;
    end else begin
      state   <= state_nx;
      dv_prev <= RX_DV;

      // Header byte position restarts whenever the state changes.
      if (state_nx != state) byte_cnt <= '0;
      else                   byte_cnt <= byte_cnt + 3'd1;

      if (state == S_PREAMBLE) begin
        ucast_ok <= 1'b1;
        bcast_ok <= 1'b1;
      end

      if (state == S_MAC_DST && RX_DV) begin
        ucast_ok <= ucast_ok && (RXD == mac_byte);
        bcast_ok <= bcast_ok && (RXD == 8'hFF);
      end

      if (state == S_MAC_SRC && RX_DV) src_shadow <= {src_shadow[39:0], RXD};

      if (state == S_LEN_TYPE && RX_DV) begin
        if (byte_cnt == 3'd0)  type_hi     <= RXD;
        else if (type_hit)     chan_shadow <= type_idx;
      end

      // Per-frame payload bookkeeping is cleared while idle.
      if (state == S_IDLE) begin
        fill    <= '0;
        pcnt    <= '0;
        aborted <= 1'b0;
      end

      if (shift_en) begin
        dline <= {dline[2:0], RXD};
        if (!full) fill <= fill + 3'd1;
      end

      if (emit) pcnt <= pcnt + 11'd1;

      if (abort_go) begin
        aborted    <= 1'b1;
        abort_code <= abort_code_nx;
      end

      rx_payload_valid <= emit;
      rx_payload_sof   <= emit && (pcnt == 11'd0);
      if (emit) rx_payload <= dline[3];
      if (emit && (pcnt == 11'd0)) begin
        rx_chan    <= chan_shadow;
        rx_mac_src <= src_shadow;
      end

      rx_done <= (state == S_DONE);
      rx_irq  <= (state == S_DONE) && (status_now == ST_OK);
      if (state == S_DONE) begin
        rx_status <= status_now;
        if (status_now == ST_OK) begin
          if (~&rx_frame_cnt) rx_frame_cnt <= rx_frame_cnt + CNT_W'(1);
        end else begin
          if (~&rx_drop_cnt)  rx_drop_cnt  <= rx_drop_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_ethernet_filter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rx_ethernet_filter
// Purpose  : Self-checking bench for rx_ethernet_filter. Frames are driven
//            from a directed table; expected payload bytes and end-of-frame
//            records are queued when a frame is issued and a monitor pops
//            and compares them as the DUT presents them. A second instance
//            with broadcast acceptance disabled shares the GMII inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_ethernet_filter;

  logic        RX_CLK = 1'b0;
  logic        rst;
  logic [47:0] mac_addr;
  logic        RX_DV;
  logic [7:0]  RXD;
  logic        RX_ER;

  logic [7:0]  rx_payload;
  logic        rx_payload_valid, rx_payload_sof;
  logic [0:0]  rx_chan;
  logic [47:0] rx_mac_src;
  logic        rx_done, rx_irq;
  logic [1:0]  rx_status;
  logic [15:0] rx_frame_cnt, rx_drop_cnt;

  logic [7:0]  nb_payload;
  logic        nb_valid, nb_sof;
  logic [0:0]  nb_chan;
  logic [47:0] nb_mac_src;
  logic        nb_done, nb_irq;
  logic [1:0]  nb_status;
  logic [15:0] nb_frame_cnt, nb_drop_cnt;

  always #4 RX_CLK = ~RX_CLK;

  rx_ethernet_filter dut (
    .RX_CLK(RX_CLK), .rst(rst), .mac_addr(mac_addr),
    .RX_DV(RX_DV), .RXD(RXD), .RX_ER(RX_ER),
    .rx_payload(rx_payload), .rx_payload_valid(rx_payload_valid),
    .rx_payload_sof(rx_payload_sof), .rx_chan(rx_chan), .rx_mac_src(rx_mac_src),
    .rx_done(rx_done), .rx_status(rx_status), .rx_irq(rx_irq),
    .rx_frame_cnt(rx_frame_cnt), .rx_drop_cnt(rx_drop_cnt)
  );

  rx_ethernet_filter #(.ACCEPT_BCAST(1'b0)) dut_nb (
    .RX_CLK(RX_CLK), .rst(rst), .mac_addr(mac_addr),
    .RX_DV(RX_DV), .RXD(RXD), .RX_ER(RX_ER),
    .rx_payload(nb_payload), .rx_payload_valid(nb_valid),
    .rx_payload_sof(nb_sof), .rx_chan(nb_chan), .rx_mac_src(nb_mac_src),
    .rx_done(nb_done), .rx_status(nb_status), .rx_irq(nb_irq),
    .rx_frame_cnt(nb_frame_cnt), .rx_drop_cnt(nb_drop_cnt)
  );

`ifdef RX_FCS_CHECK_EN
  localparam int BAD_FCS_ST = 1;
`else
  localparam int BAD_FCS_ST = 0;
`endif

  localparam logic [47:0] SELF  = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] SRC_A = 48'h0A_0B_0C_0D_0E_0F;
  localparam logic [47:0] SRC_B = 48'h12_34_56_78_9A_BC;

  typedef struct packed {
    logic [7:0]  d;
    logic        sof;
    logic [0:0]  chan;
    logic [47:0] src;
  } pay_t;

  typedef struct packed {
    logic [1:0]  st;
    logic [15:0] fc;
    logic [15:0] dc;
  } done_t;

  pay_t  pay_q[$];
  done_t done_q[$];
  pay_t  mp;
  done_t md;

  int errors = 0;
  int checks = 0;
  int exp_fc = 0, exp_dc = 0, nb_fc = 0, nb_dc = 0;
  bit nb_window = 1'b0;
  int nb_seen = 0;

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  always @(negedge RX_CLK) begin
    if (!rst) begin
      if (rx_payload_valid) begin
        checks++;
        if (pay_q.size() == 0) begin
          errors++;
          $display("FAIL payload_unexpected: got byte %02h, expected no payload", rx_payload);
        end else begin
          mp = pay_q.pop_front();
          if (rx_payload !== mp.d || rx_payload_sof !== mp.sof) begin
            errors++;
            $display("FAIL payload_byte: got %02h sof=%0b, expected %02h sof=%0b",
                     rx_payload, rx_payload_sof, mp.d, mp.sof);
          end
          if (mp.sof) begin
            checks++;
            if (rx_chan !== mp.chan || rx_mac_src !== mp.src) begin
              errors++;
              $display("FAIL sof_fields: got chan=%0d src=%012h, expected chan=%0d src=%012h",
                       rx_chan, rx_mac_src, mp.chan, mp.src);
            end
          end
        end
      end
      if (rx_done) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: got rx_done status=%0d, expected no rx_done", rx_status);
        end else begin
          md = done_q.pop_front();
          if (rx_status !== md.st || rx_irq !== (md.st == 2'd0) ||
              rx_frame_cnt !== md.fc || rx_drop_cnt !== md.dc) begin
            errors++;
            $display("FAIL done_status: got status=%0d irq=%0b fc=%0d dc=%0d, expected status=%0d irq=%0b fc=%0d dc=%0d",
                     rx_status, rx_irq, rx_frame_cnt, rx_drop_cnt,
                     md.st, (md.st == 2'd0), md.fc, md.dc);
          end
        end
      end
      if (rx_irq && !rx_done) begin
        checks++;
        errors++;
        $display("FAIL irq_alone: got rx_irq=1 rx_done=0, expected irq only with done");
      end
      if (nb_window && (nb_valid || nb_done)) nb_seen++;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  function automatic logic [31:0] crc32(input logic [7:0] bytes[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    foreach (bytes[k]) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ bytes[k][j];
        c  = {1'b0, c[31:1]};
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  task automatic drive_byte(input logic [7:0] b, input logic er);
    @(posedge RX_CLK); #1;
    RX_DV = 1'b1;
    RXD   = b;
    RX_ER = er;
  endtask

  task automatic idle_gap(input int n);
    @(posedge RX_CLK); #1;
    RX_DV = 1'b0;
    RX_ER = 1'b0;
    RXD   = 8'h00;
    repeat (n) @(posedge RX_CLK);
  endtask

  // er_at: payload index carrying RX_ER (-1 none). exp_st: -1 = no rx_done.
  task automatic send_frame(input logic [47:0] dst, input logic [47:0] src,
                            input logic [15:0] etype, input int n, input int er_at,
                            input bit bad_fcs, input bit bad_pre,
                            input logic [0:0] exp_chan, input int exp_bytes,
                            input int exp_st, input bit is_bcast);
    logic [7:0]  body[$];
    logic [7:0]  pre[$];
    logic [31:0] fcs;
    done_t       d;
    for (int i = 0; i < 7; i++) pre.push_back((bad_pre && i == 3) ? 8'hAA : 8'h55);
    pre.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) body.push_back(dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) body.push_back(src[8*i +: 8]);
    body.push_back(etype[15:8]);
    body.push_back(etype[7:0]);
    for (int i = 0; i < n; i++) body.push_back(8'(i));
    fcs = crc32(body);
    body.push_back(fcs[7:0]);
    body.push_back(fcs[15:8]);
    body.push_back(fcs[23:16]);
    body.push_back(bad_fcs ? ~fcs[31:24] : fcs[31:24]);

    for (int i = 0; i < exp_bytes; i++)
      pay_q.push_back('{d: 8'(i), sof: (i == 0), chan: exp_chan, src: src});
    if (exp_st >= 0) begin
      if (exp_st == 0) exp_fc++; else exp_dc++;
      if (!is_bcast) begin
        if (exp_st == 0) nb_fc++; else nb_dc++;
      end
      d.st = 2'(exp_st);
      d.fc = 16'(exp_fc);
      d.dc = 16'(exp_dc);
      done_q.push_back(d);
    end

    foreach (pre[i])  drive_byte(pre[i], 1'b0);
    foreach (body[i]) drive_byte(body[i], (er_at >= 0) && (i == 14 + er_at));
    idle_gap(16);
  endtask

  task automatic drain_and_check(input string tag);
    int budget;
    budget = 200;
    while ((pay_q.size() != 0 || done_q.size() != 0) && budget > 0) begin
      @(posedge RX_CLK);
      budget--;
    end
    @(negedge RX_CLK);
    checks++;
    if (pay_q.size() != 0) begin
      errors++;
      $display("FAIL %s_payload_drain: got %0d bytes still expected, required 0", tag, pay_q.size());
    end
    checks++;
    if (done_q.size() != 0) begin
      errors++;
      $display("FAIL %s_done_drain: got %0d rx_done still expected, required 0", tag, done_q.size());
    end
  endtask

  task automatic check_counters(input string tag);
    @(negedge RX_CLK);
    checks++;
    if (rx_frame_cnt !== 16'(exp_fc) || rx_drop_cnt !== 16'(exp_dc)) begin
      errors++;
      $display("FAIL %s_counters: got fc=%0d dc=%0d, expected fc=%0d dc=%0d",
               tag, rx_frame_cnt, rx_drop_cnt, exp_fc, exp_dc);
    end
    checks++;
    if (nb_frame_cnt !== 16'(nb_fc) || nb_drop_cnt !== 16'(nb_dc)) begin
      errors++;
      $display("FAIL %s_nb_counters: got fc=%0d dc=%0d, expected fc=%0d dc=%0d",
               tag, nb_frame_cnt, nb_drop_cnt, nb_fc, nb_dc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------------
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation still running at 1 ms, expected completion earlier");
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    rst      = 1'b1;
    mac_addr = SELF;
    RX_DV    = 1'b0;
    RXD      = 8'h00;
    RX_ER    = 1'b0;
    repeat (4) @(posedge RX_CLK);
    #1 rst = 1'b0;

    @(negedge RX_CLK);
    checks++;
    if (rx_payload_valid !== 1'b0 || rx_payload_sof !== 1'b0 || rx_done !== 1'b0 ||
        rx_irq !== 1'b0 || rx_status !== 2'd0 || rx_payload !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b sof=%0b done=%0b irq=%0b status=%0d data=%02h, expected all 0",
               rx_payload_valid, rx_payload_sof, rx_done, rx_irq, rx_status, rx_payload);
    end
    checks++;
    if (rx_frame_cnt !== 16'd0 || rx_drop_cnt !== 16'd0 || rx_chan !== 1'b0 || rx_mac_src !== 48'd0) begin
      errors++;
      $display("FAIL reset_regs: got fc=%0d dc=%0d chan=%0d src=%012h, expected all 0",
               rx_frame_cnt, rx_drop_cnt, rx_chan, rx_mac_src);
    end

    // dst, src, type, n, er_at, bad_fcs, bad_pre, chan, bytes, status, bcast
    send_frame(SELF,  SRC_A, 16'h0800,   46, -1, 0, 0, 1'b0,   46,  0, 0); // good IPv4
    nb_seen   = 0;
    nb_window = 1'b1;
    send_frame(BCAST, SRC_B, 16'h0806,   46, -1, 0, 0, 1'b1,   46,  0, 1); // broadcast ARP
    nb_window = 1'b0;
    checks++;
    if (nb_seen != 0) begin
      errors++;
      $display("FAIL nb_bcast_silent: got %0d output cycles, expected 0", nb_seen);
    end
    send_frame(SELF,  SRC_A, 16'h86DD,   46, -1, 0, 0, 1'b0,    0, -1, 0); // unknown type
    send_frame(SELF,  SRC_A, 16'h0040,   46, -1, 0, 0, 1'b0,    0, -1, 0); // length field
    send_frame(SELF,  SRC_B, 16'h0800,   20, -1, 0, 0, 1'b0,   20,  2, 0); // runt
    send_frame(SELF,  SRC_A, 16'h0800,   46, 10, 0, 0, 1'b0,    7,  3, 0); // RX_ER mid-payload
    send_frame(SELF,  SRC_A, 16'h0800,   46, -1, 1, 0, 1'b0,   46, BAD_FCS_ST, 0); // bad FCS
    send_frame(OTHER, SRC_A, 16'h0800,   46, -1, 0, 0, 1'b0,    0, -1, 0); // not for us
    send_frame(SELF,  SRC_A, 16'h0800,   46, -1, 0, 1, 1'b0,    0, -1, 0); // bad preamble
    send_frame(SELF,  SRC_B, 16'h0806,   45, -1, 0, 0, 1'b1,   45,  2, 0); // one short of min
    send_frame(SELF,  SRC_A, 16'h0800, 1500, -1, 0, 0, 1'b0, 1500,  0, 0); // exactly max
    send_frame(SELF,  SRC_B, 16'h0800, 1501, -1, 0, 0, 1'b0, 1500,  2, 0); // giant
    drain_and_check("main");
    check_counters("main");

    // Reset in the middle of the source address: no rx_done, counters cleared.
    for (int i = 0; i < 7; i++) drive_byte(8'h55, 1'b0);
    drive_byte(8'hD5, 1'b0);
    for (int i = 5; i >= 0; i--) drive_byte(SELF[8*i +: 8], 1'b0);
    for (int i = 5; i >= 3; i--) drive_byte(SRC_A[8*i +: 8], 1'b0);
    @(posedge RX_CLK); #1;
    rst   = 1'b1;
    RX_DV = 1'b0;
    repeat (2) @(posedge RX_CLK);
    #1 rst = 1'b0;
    exp_fc = 0; exp_dc = 0; nb_fc = 0; nb_dc = 0;
    check_counters("midreset");
    repeat (4) @(posedge RX_CLK);

    send_frame(SELF, SRC_B, 16'h0800, 46, -1, 0, 0, 1'b0, 46, 0, 0);
    drain_and_check("post");
    check_counters("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_ethernet_filter.md
Name: rx_ethernet_filter

Overview:
- Parametrised GMII receive MAC front end; successor to the single-EtherType IPv4 receiver.
- Parses preamble/SFD, destination MAC, source MAC and EtherType.
- Accepts unicast-to-self and (optionally) broadcast frames, and matches the EtherType against a parameter table of NUM_TYPES entries.
- Streams payload with the 4-byte FCS stripped, and reports per-frame status plus saturating counters to the next-layer demux.

Parameters:
- OCT, 8, bits per GMII byte.
- NUM_TYPES, 2, number of accepted EtherTypes (1..8).
- TYPE_LIST, {16'h0806,16'h0800}, NUM_TYPES*16 bits; entry i = bits [16*i+15:16*i]; IPv4 is entry 0.
- ACCEPT_BCAST, 1, 1 = also accept dst FF:FF:FF:FF:FF:FF.
- MIN_PAYLOAD, 46, minimum payload bytes (FCS excluded); below = runt.
- MAX_PAYLOAD, 1500, maximum payload bytes; above = giant.
- CNT_W, 16, width of statistics counters.

Ports:
- RX_CLK  in  1  GMII receive clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- mac_addr  in  48  station address, sampled during MAC_DST.
- RX_DV  in  1  GMII data valid.
- RXD  in  8  GMII data.
- RX_ER  in  1  GMII receive error.
- rx_payload  out  8  payload byte.
- rx_payload_valid  out  1  rx_payload valid this cycle.
- rx_payload_sof  out  1  with valid: first payload byte.
- rx_chan  out  max(1,clog2(NUM_TYPES))  matched TYPE_LIST index; stable from sof until rx_done.
- rx_mac_src  out  48  source MAC of current frame; valid from sof.
- rx_done  out  1  one-cycle pulse at end of an accepted frame.
- rx_status  out  2  valid with rx_done: 0 ok, 1 FCS bad, 2 runt/giant, 3 PHY error/truncated.
- rx_irq  out  1  one-cycle pulse with rx_done when rx_status==0.
- rx_frame_cnt  out  CNT_W  frames with status 0; saturating.
- rx_drop_cnt  out  CNT_W  frames ending with status !=0; saturating.

Behaviour:
- Reset values: all outputs 0; state IDLE; shift register and byte counters cleared.
- RX_DV edge detection uses a registered previous RX_DV.
- States and transitions:
  - IDLE: go to PREAMBLE on RX_DV rising.
  - PREAMBLE: stay while RXD==8'h55; 8'hD5 -> MAC_DST; any other byte -> DISCARD, with no status and no count.
  - MAC_DST: 6 bytes, MSB first. On byte 6, compare the byte with {mac_addr} or, if ACCEPT_BCAST, with broadcast. Mismatch -> DISCARD silently.
  - MAC_SRC: 6 bytes into the rx_mac_src shadow register; copied to the output at sof.
  - LEN_TYPE: 2 bytes. The lowest matching TYPE_LIST index sets rx_chan. No match (including length values <=1500) -> DISCARD silently.
  - PAYLOAD: bytes enter a 4-deep delay line. Once 4 bytes are held, each new byte pushes the oldest byte out as rx_payload with valid=1. The first pushed-out byte carries sof.
  - RX_DV falling in PAYLOAD -> DONE. The 4 held bytes are the FCS and are never output.
  - DONE: one cycle; pulse rx_done/rx_irq and update counters; then IDLE.
  - DISCARD: output nothing; wait for RX_DV==0; then IDLE.
- Payload latency: each payload byte is output 4 bytes (4 RX_CLK cycles) after it appears on RXD, plus 1 register stage.
- Payload count is an 11-bit counter of bytes output.
  - Count reaching MAX_PAYLOAD+1 stops output immediately. Go to DISCARD-with-status: when RX_DV falls, pulse rx_done with status 2.
  - At DONE, count < MIN_PAYLOAD -> status 2.
- RX_ER=1 with RX_DV=1 in any state past PREAMBLE:
  - If payload has started, stop output and end the frame with status 3.
  - Otherwise DISCARD silently.
- RX_DV falling in MAC_DST..LEN_TYPE -> IDLE, silently.
- Status precedence when several apply: 3 > 2 > 1.
- RX_DV rising while in DONE is ignored; that frame is lost.
- Reset mid-frame: immediate return to IDLE. No rx_done is issued; counters are cleared.

Optional Feature:
- Macro RX_FCS_CHECK_EN.
- Defined:
  - CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) is updated per byte from the first MAC_DST byte through the last FCS byte.
  - At DONE, a residue other than 0xC704DD7B gives status 1 (subject to the precedence rule).
- Not defined: no CRC logic; status 1 is never produced; the FCS is still stripped.

Test Plan:
- 7x55, D5, dst=mac_addr 02:00:00:00:00:01, type 0800, 46 payload bytes 00..2D, valid FCS -> 46 valid bytes, sof on 00, rx_chan=0, rx_done+rx_irq, status 0, rx_frame_cnt=1.
- Same frame but dst FF:FF:FF:FF:FF:FF with type 0806 -> accepted, rx_chan=1; with ACCEPT_BCAST=0 -> no valid, no rx_done, counters unchanged.
- Type 86DD or length 0040 -> no payload output, no rx_done, counters unchanged.
- Frame with 20 payload bytes -> 20 valid bytes, rx_done with status 2, rx_drop_cnt=1, no rx_irq.
- RX_ER pulsed at payload byte 10 -> output stops after the byte that was due that cycle; at RX_DV fall rx_done with status 3.
- RX_FCS_CHECK_EN defined, last FCS byte flipped -> status 1, rx_drop_cnt+1. Without the macro, the same frame gives status 0.
